// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan driver.
package seg_pkg;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_ZERO   = 7'h40;
  localparam logic [3:0]  AN_OFF     = 4'hF;
  localparam int unsigned NUM_DIGITS = 3;

  // Digit index: 0 = ones, 1 = tens, 2 = hundreds.
  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

endpackage

// File: rtl/seg_refresh_tick.sv
// Digit-slot prescaler: counts clk cycles within a slot, flags the last
// cycle of a slot and the anti-ghosting guard window at its start.
module seg_refresh_tick #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic slot_wrap_o,
  output logic in_guard_o
);

  localparam int unsigned CntW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] CntGuard = CntW'(GUARD);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Slot cycle counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count while enabled, wrap at the end of a slot, park at 0 when disabled.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  // Slot status flags.
  always_comb begin
    slot_wrap_o = en_i && (cnt_q == CntMax);
    in_guard_o  = (cnt_q < CntGuard);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes three active-low digit patterns onto a 4-digit
// common-anode display with tear-free shadowing, a guard interval,
// optional leading-zero blanking and a per-frame strobe.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic       blank_lz,
  input  logic [6:0] hundreds,
  input  logic [6:0] tens,
  input  logic [6:0] ones,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_done
);

  logic       slot_wrap, in_guard, frame_end, xfer;
  logic       hund_blank, tens_blank;
  digit_idx_t idx_q, idx_d;
  logic [6:0] pend_q [NUM_DIGITS];
  logic [6:0] pend_d [NUM_DIGITS];
  logic [6:0] act_q  [NUM_DIGITS];
  logic [6:0] act_d  [NUM_DIGITS];
  logic [6:0] disp   [NUM_DIGITS];
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic       fd_q, fd_d;

  seg_refresh_tick #(
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD      (GUARD)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .slot_wrap_o(slot_wrap),
    .in_guard_o (in_guard)
  );

  assign frame_end = slot_wrap && (idx_q == IDX_LAST);
  // While disabled the boundary transfer is continuous.
  assign xfer      = !en || frame_end;

  // State register: digit index, shadows and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pend_q[i] <= SEG_BLANK;
        act_q[i]  <= SEG_BLANK;
      end
      seg_q <= SEG_BLANK;
      an_q  <= AN_OFF;
      fd_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end

  // Next digit index: advance on slot wrap, restart at ones when disabled.
  always_comb begin
    idx_d = idx_q;
    if (!en) begin
      idx_d = '0;
    end else if (slot_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Shadow capture; pend_d already holds fresh inputs on a load, so a
  // load coinciding with a boundary lands in active the same cycle.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    if (load) begin
      pend_d[0] = ones;
      pend_d[1] = tens;
      pend_d[2] = hundreds;
    end
    if (xfer) begin
      act_d = pend_d;
    end
  end

  // Leading-zero blanking on the active patterns; ones is never blanked.
  always_comb begin
    hund_blank = blank_lz && (act_q[2] == SEG_ZERO);
    tens_blank = hund_blank && (act_q[1] == SEG_ZERO);
    disp[0]    = act_q[0];
    disp[1]    = tens_blank ? SEG_BLANK : act_q[1];
    disp[2]    = hund_blank ? SEG_BLANK : act_q[2];
  end

  // Output decode from the current scan position.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    fd_d  = frame_end;
    if (en && !in_guard) begin
      unique case (idx_q)
        2'd0: begin seg_d = disp[0]; an_d = 4'b1110; end
        2'd1: begin seg_d = disp[1]; an_d = 4'b1101; end
        2'd2: begin seg_d = disp[2]; an_d = 4'b1011; end
        default: begin seg_d = SEG_BLANK; an_d = AN_OFF; end
      endcase
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = 1'b1;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a frame-position reference model.
module tb_seg_scan_driver;

  localparam int unsigned RD    = 8;
  localparam int unsigned GD    = 2;
  localparam int          FRAME = 3 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, load = 1'b0, blank_lz = 1'b0;
  logic [6:0] hundreds = 7'h7F, tens = 7'h7F, ones = 7'h7F;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp, frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .REFRESH_DIV(RD),
    .GUARD      (GD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .blank_lz  (blank_lz),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .frame_done(frame_done)
  );

  int checks   = 0;
  int failures = 0;

  // Model: position within a 24-cycle frame; digit 0=ones,1=tens,2=hundreds.
  int         pos;
  logic [6:0] m_pend [3];
  logic [6:0] m_act  [3];
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_fd;

  typedef struct {
    logic       blz;
    logic [6:0] h, t, o;
    logic [6:0] e0, e1, e2;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 7'h7F;
      m_act[i]  = 7'h7F;
    end
  endtask

  function automatic logic [6:0] shown(input int d);
    logic hb, tb;
    hb = blank_lz && (m_act[2] == 7'h40);
    tb = hb && (m_act[1] == 7'h40);
    if (d == 2 && hb) return 7'h7F;
    if (d == 1 && tb) return 7'h7F;
    return m_act[d];
  endfunction

  // Expected registered outputs follow the pre-edge position; then state advances.
  task automatic model_step();
    int  d;
    logic boundary;
    d = pos / RD;
    if (!en || (pos % RD) < GD) begin
      exp_seg = 7'h7F;
      exp_an  = 4'hF;
    end else begin
      exp_seg = shown(d);
      exp_an  = 4'hF & ~(4'b0001 << d);
    end
    exp_fd   = en && (pos == FRAME - 1);
    boundary = !en || (pos == FRAME - 1);
    if (load) begin
      m_pend[0] = ones;
      m_pend[1] = tens;
      m_pend[2] = hundreds;
    end
    if (boundary) m_act = m_pend;
    pos = en ? (pos + 1) % FRAME : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("cycle", {19'd0, seg, an, dp, frame_done}, {19'd0, exp_seg, exp_an, 1'b1, exp_fd});
  endtask

  task automatic do_load(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
    hundreds = h; tens = t; ones = o; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 2 * FRAME && pos != target; k++) tick();
    check("reach_pos", pos, target);
  endtask

  task automatic observe(input int n, output logic [6:0] o0, output logic [6:0] o1,
                         output logic [6:0] o2);
    o0 = 7'h00; o1 = 7'h00; o2 = 7'h00;
    for (int k = 0; k < n; k++) begin
      tick();
      if (an == 4'b1110) o0 = seg;
      if (an == 4'b1101) o1 = seg;
      if (an == 4'b1011) o2 = seg;
    end
  endtask

  initial begin
    logic [6:0] o0, o1, o2;
    int first_fd, second_fd, seen;

    vecs[0] = '{1'b0, 7'h79, 7'h24, 7'h30, 7'h30, 7'h24, 7'h79};
    vecs[1] = '{1'b1, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F};
    vecs[2] = '{1'b1, 7'h40, 7'h79, 7'h40, 7'h40, 7'h79, 7'h7F};
    vecs[3] = '{1'b1, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79};
    vecs[4] = '{1'b1, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[5] = '{1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", {19'd0, seg, an, dp, frame_done}, {19'd0, 7'h7F, 4'hF, 1'b1, 1'b0});
    rst = 1'b0;
    model_reset();
    tick();

    // Basic scan with 1/2/3 and frame period
    en = 1'b1;
    do_load(7'h79, 7'h24, 7'h30);
    first_fd = -1; second_fd = -1;
    for (int k = 0; k < 80 && second_fd < 0; k++) begin
      tick();
      if (frame_done) begin
        if (first_fd < 0) first_fd = k;
        else second_fd = k;
      end
    end
    check("frame_period", second_fd - first_fd, FRAME);
    observe(FRAME, o0, o1, o2);
    check("scan_ones", o0, 7'h30);
    check("scan_tens", o1, 7'h24);
    check("scan_hund", o2, 7'h79);

    // Table of blanking / pass-through vectors
    foreach (vecs[i]) begin
      blank_lz = vecs[i].blz;
      do_load(vecs[i].h, vecs[i].t, vecs[i].o);
      observe(2 * FRAME, o0, o1, o2);
      check("vec_ones", o0, vecs[i].e0);
      check("vec_tens", o1, vecs[i].e1);
      check("vec_hund", o2, vecs[i].e2);
    end

    // Tear-free update: new load mid idx1 must not show until next idx0
    blank_lz = 1'b0;
    do_load(7'h79, 7'h24, 7'h30);
    run_to(0);
    run_to(RD + 3);
    do_load(7'h40, 7'h40, 7'h40);
    o0 = 7'h00; o1 = 7'h00; o2 = 7'h00; seen = 0;
    for (int k = 0; k < 2 * FRAME && seen < 3; k++) begin
      tick();
      if (seen == 0 && an == 4'b1101) o1 = seg;
      if (an == 4'b1011) begin o2 = seg; seen = 1; end
      if (seen >= 1 && an == 4'b1110) begin o0 = seg; seen = 3; end
    end
    check("tear_tens_old", o1, 7'h24);
    check("tear_hund_old", o2, 7'h79);
    check("tear_ones_new", o0, 7'h40);

    // Enable gating mid-slot
    run_to(RD + 5);
    en = 1'b0;
    tick();
    check("en_off", {seg, an, frame_done}, {7'h7F, 4'hF, 1'b0});
    repeat (3) tick();
    en = 1'b1;
    tick(); check("en_guard0", an, 4'hF);
    tick(); check("en_guard1", an, 4'hF);
    tick(); check("en_restart", an, 4'b1110);

    // Load on the frame boundary
    run_to(FRAME - 1);
    do_load(7'h79, 7'h24, 7'h12);
    repeat (GD) tick();
    tick();
    check("bnd_load_ones", {seg, an}, {7'h12, 4'b1110});

    // Asynchronous reset during idx2
    run_to(2 * RD + 4);
    tick();
    #3 rst = 1'b1;
    #1;
    check("async_rst", {seg, an, frame_done}, {7'h7F, 4'hF, 1'b0});
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    observe(FRAME + 2, o0, o1, o2);
    check("post_rst_blank", {o0, o1, o2}, {7'h7F, 7'h7F, 7'h7F});

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      logic [6:0] pool [4];
      pool[0] = 7'h40; pool[1] = 7'h79; pool[2] = 7'h24; pool[3] = 7'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      blank_lz = ($urandom_range(0, 31) == 0) ? ~blank_lz : blank_lz;
      en       = ($urandom_range(0, 49) == 0) ? ~en : (en | ($urandom_range(0, 9) == 0));
      hundreds = pool[$urandom_range(0, 3)];
      tens     = pool[$urandom_range(0, 3)];
      ones     = pool[$urandom_range(0, 3)];
      tick();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
